// File: rtl/atsc_rx_pkg.sv
// Shared constants, types and arithmetic helpers for the ATSC RX AGC stage.
package atsc_rx_pkg;

    // Sample packing: I in the upper half-word, Q in the lower half-word.
    localparam int I_MSB  = 31;
    localparam int Q_MSB  = 15;
    localparam int SAMP_W = 16;

    // Gain format is unsigned Q4.12.
    localparam int                 GAIN_FRAC  = 12;
    localparam logic [15:0]        GAIN_ONE   = 16'h1000;
    localparam logic signed [32:0] ROUND_HALF = 33'sd2048;

    typedef enum logic {
        LVL_ACCUM  = 1'b0,
        LVL_UPDATE = 1'b1
    } lvl_state_t;

    // Signed sample times unsigned gain, rounded half-up, back to integer scale.
    function automatic logic signed [32:0] scale_round(
        input logic signed [SAMP_W-1:0] samp,
        input logic        [15:0]       gain
    );
        logic signed [32:0] prod;
        prod = $signed({{17{samp[SAMP_W-1]}}, samp}) * $signed({17'd0, gain});
        return (prod + ROUND_HALF) >>> GAIN_FRAC;
    endfunction

    // Clip a wide signed value into the sc16 range.
    function automatic logic [SAMP_W-1:0] sat16(input logic signed [32:0] x);
        logic [SAMP_W-1:0] r;
        if (x > 33'sd32767) begin
            r = 16'h7FFF;
        end else if (x < -33'sd32768) begin
            r = 16'h8000;
        end else begin
            r = x[SAMP_W-1:0];
        end
        return r;
    endfunction

    // Magnitude of a signed 16-bit value; 17 bits so that |-32768| is exact.
    function automatic logic [16:0] abs17(input logic [SAMP_W-1:0] v);
        logic [16:0] r;
        if (v[SAMP_W-1]) begin
            r = ~{v[SAMP_W-1], v} + 17'd1;
        end else begin
            r = {1'b0, v};
        end
        return r;
    endfunction

endpackage

// File: rtl/atsc_rx_agc_level.sv
// Output level measurement and gain loop: windowed mean of |I|+|Q|,
// proportional correction towards TARGET, clamped gain register.
module atsc_rx_agc_level
    import atsc_rx_pkg::*;
#(
    parameter int          WIN_LOG2   = 10,
    parameter logic [16:0] TARGET     = 17'd8192,
    parameter logic [15:0] GAIN_INIT  = GAIN_ONE,
    parameter int          STEP_SHIFT = 4,
    parameter logic [15:0] GAIN_MIN   = 16'h0040,
    parameter logic [15:0] GAIN_MAX   = 16'hFFFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hs_i,
    input  logic [SAMP_W-1:0] i_i,
    input  logic [SAMP_W-1:0] q_i,
    input  logic              freeze_i,
    output logic [15:0]       gain_o,
    output logic [16:0]       mean_o,
    output logic              win_stb_o
);

    localparam int                  ACC_W   = 17 + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_MAX = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] CNT_ONE = WIN_LOG2'(1);

    lvl_state_t          state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum_s;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [16:0]         mean_q, mean_d, mag_s;
    logic                stb_q, stb_d;
    logic [15:0]         gain_q, gain_d, clamp_s;
    logic                wrap_s;
    logic signed [17:0]  err_s, step_s;
    logic signed [18:0]  cand_s;

    // Magnitude of the handshaken sample, running sum and window-end detect.
    always_comb begin
        mag_s     = abs17(i_i) + abs17(q_i);
        acc_sum_s = acc_q + ACC_W'(mag_s);
        wrap_s    = hs_i & (cnt_q == CNT_MAX);
    end

    // Proportional correction from the latched mean, clamped to the gain range.
    always_comb begin
        err_s  = $signed({1'b0, TARGET}) - $signed({1'b0, mean_q});
        step_s = err_s >>> STEP_SHIFT;
        cand_s = $signed({3'b000, gain_q}) + 19'(step_s);
        if (cand_s < $signed({3'b000, GAIN_MIN})) begin
            clamp_s = GAIN_MIN;
        end else if (cand_s > $signed({3'b000, GAIN_MAX})) begin
            clamp_s = GAIN_MAX;
        end else begin
            clamp_s = cand_s[15:0];
        end
    end

    // Next-state logic for the accumulator, window counter, mean latch and FSM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mean_d  = mean_q;
        stb_d   = 1'b0;
        gain_d  = gain_q;
        if (hs_i) begin
            cnt_d = cnt_q + CNT_ONE;
            if (wrap_s) begin
                acc_d  = {ACC_W{1'b0}};
                mean_d = acc_sum_s[ACC_W-1:WIN_LOG2];
                stb_d  = 1'b1;
            end else begin
                acc_d = acc_sum_s;
            end
        end else begin
            cnt_d = cnt_q;
            acc_d = acc_q;
        end
        case (state_q)
            LVL_ACCUM: begin
                if (wrap_s) begin
                    state_d = LVL_UPDATE;
                end else begin
                    state_d = LVL_ACCUM;
                end
            end
            LVL_UPDATE: begin
                if (!freeze_i) begin
                    gain_d = clamp_s;
                end else begin
                    gain_d = gain_q;
                end
                // A window can only end here when it is a single sample long.
                if (wrap_s) begin
                    state_d = LVL_UPDATE;
                end else begin
                    state_d = LVL_ACCUM;
                end
            end
            default: begin
                state_d = LVL_ACCUM;
            end
        endcase
    end

    // Level-loop state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LVL_ACCUM;
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {WIN_LOG2{1'b0}};
            mean_q  <= 17'd0;
            stb_q   <= 1'b0;
            gain_q  <= GAIN_INIT;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mean_q  <= mean_d;
            stb_q   <= stb_d;
            gain_q  <= gain_d;
        end
    end

    assign gain_o    = gain_q;
    assign mean_o    = mean_q;
    assign win_stb_o = stb_q;

endmodule

// File: rtl/atsc_rx_agc.sv
// AGC stage in front of the ATSC RX filter: 3-stage scaling pipeline on an
// AXI-Stream sc16 path, with gain driven by the output level loop.
module atsc_rx_agc
    import atsc_rx_pkg::*;
#(
    parameter int          WIN_LOG2   = 10,
    parameter logic [16:0] TARGET     = 17'd8192,
    parameter logic [15:0] GAIN_INIT  = GAIN_ONE,
    parameter int          STEP_SHIFT = 4,
    parameter logic [15:0] GAIN_MIN   = 16'h0040,
    parameter logic [15:0] GAIN_MAX   = 16'hFFFF
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic        cfg_freeze,
    output logic [15:0] gain_out,
    output logic [16:0] mean_out,
    output logic        win_stb
);

    logic               adv_s;
    logic               out_hs_s;
    logic [15:0]        gain_s;

    logic               s1_vld_q, s1_last_q;
    logic [31:0]        s1_data_q;
    logic               s2_vld_q, s2_last_q;
    logic signed [32:0] s2_i_q, s2_q_q, s2_i_d, s2_q_d;
    logic               out_vld_q, out_last_q;
    logic [31:0]        out_data_q, out_data_d;

    // Whole pipeline moves together whenever the output slot is free or draining.
    always_comb begin
        adv_s    = ~out_vld_q | m_axis_tready;
        out_hs_s = out_vld_q & m_axis_tready;
    end

    // Scaling in S2 and saturation in S3.
    always_comb begin
        s2_i_d     = scale_round(s1_data_q[I_MSB -: SAMP_W], gain_s);
        s2_q_d     = scale_round(s1_data_q[Q_MSB -: SAMP_W], gain_s);
        out_data_d = {sat16(s2_i_q), sat16(s2_q_q)};
    end

    // Pipeline registers; bubbles advance like samples so nothing is compressed.
    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= 32'd0;
            s2_vld_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_i_q     <= 33'sd0;
            s2_q_q     <= 33'sd0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= 32'd0;
        end else if (adv_s) begin
            s1_vld_q   <= s_axis_tvalid;
            s1_last_q  <= s_axis_tlast;
            s1_data_q  <= s_axis_tdata;
            s2_vld_q   <= s1_vld_q;
            s2_last_q  <= s1_last_q;
            s2_i_q     <= s2_i_d;
            s2_q_q     <= s2_q_d;
            out_vld_q  <= s2_vld_q;
            out_last_q <= s2_last_q;
            out_data_q <= out_data_d;
        end else begin
            s1_vld_q   <= s1_vld_q;
            s1_last_q  <= s1_last_q;
            s1_data_q  <= s1_data_q;
            s2_vld_q   <= s2_vld_q;
            s2_last_q  <= s2_last_q;
            s2_i_q     <= s2_i_q;
            s2_q_q     <= s2_q_q;
            out_vld_q  <= out_vld_q;
            out_last_q <= out_last_q;
            out_data_q <= out_data_q;
        end
    end

    atsc_rx_agc_level #(
        .WIN_LOG2   (WIN_LOG2),
        .TARGET     (TARGET),
        .GAIN_INIT  (GAIN_INIT),
        .STEP_SHIFT (STEP_SHIFT),
        .GAIN_MIN   (GAIN_MIN),
        .GAIN_MAX   (GAIN_MAX)
    ) u_level (
        .clk_i     (ce_clk),
        .rst_i     (ce_rst),
        .hs_i      (out_hs_s),
        .i_i       (out_data_q[I_MSB -: SAMP_W]),
        .q_i       (out_data_q[Q_MSB -: SAMP_W]),
        .freeze_i  (cfg_freeze),
        .gain_o    (gain_s),
        .mean_o    (mean_out),
        .win_stb_o (win_stb)
    );

    assign s_axis_tready = adv_s;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tvalid = out_vld_q;
    assign gain_out      = gain_s;

endmodule

// File: tb/tb_atsc_rx_agc.sv
// Directed bench for atsc_rx_agc. Three instances share one input stream:
// A uses default parameters, B a 4-sample window with gain 2.0, C a 4-sample
// window with zero target so its gain can only fall.
module tb_atsc_rx_agc;

    logic        clk;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic        m_ready = 1'b1;
    logic        freeze = 1'b0;
    logic        bp_on = 1'b0;
    logic        mon_on = 1'b0;

    logic        s_rdy[3];
    logic [31:0] m_data[3];
    logic        m_last[3];
    logic        m_valid[3];
    logic        stb[3];
    logic [15:0] gain[3];
    logic [16:0] mean[3];

    int checks = 0;
    int failures = 0;
    int stall_err = 0;
    int stb_cnt = 0;
    logic [32:0] qa[$];
    logic [32:0] qb[$];

    typedef struct {
        logic [31:0] din;
        logic        last;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;
    vec_t vecs[6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    atsc_rx_agc #(.WIN_LOG2(10)) dut_a (
        .ce_clk(clk), .ce_rst(rst), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_rdy[0]), .m_axis_tdata(m_data[0]),
        .m_axis_tlast(m_last[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready),
        .cfg_freeze(freeze), .gain_out(gain[0]), .mean_out(mean[0]), .win_stb(stb[0]));

    atsc_rx_agc #(.WIN_LOG2(2), .GAIN_INIT(16'h2000)) dut_b (
        .ce_clk(clk), .ce_rst(rst), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_rdy[1]), .m_axis_tdata(m_data[1]),
        .m_axis_tlast(m_last[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready),
        .cfg_freeze(freeze), .gain_out(gain[1]), .mean_out(mean[1]), .win_stb(stb[1]));

    atsc_rx_agc #(.WIN_LOG2(2), .TARGET(17'd0), .GAIN_INIT(16'h0080)) dut_c (
        .ce_clk(clk), .ce_rst(rst), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_rdy[2]), .m_axis_tdata(m_data[2]),
        .m_axis_tlast(m_last[2]), .m_axis_tvalid(m_valid[2]), .m_axis_tready(m_ready),
        .cfg_freeze(freeze), .gain_out(gain[2]), .mean_out(mean[2]), .win_stb(stb[2]));

    // Output ready: 30% random duty while backpressure is enabled, else held high.
    always @(posedge clk) begin
        #1;
        m_ready = bp_on ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // Output collector and stall-rule watcher, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (m_valid[0] && m_ready) qa.push_back({m_last[0], m_data[0]});
            if (m_valid[1] && m_ready) qb.push_back({m_last[1], m_data[1]});
            if (m_valid[0] && !m_ready && s_rdy[0]) stall_err++;
            if (stb[0]) stb_cnt++;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        s_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // Present one sample and return just after the edge that accepts it.
    task automatic send(input logic [31:0] d, input logic l);
        logic hs;
        hs = 1'b0;
        s_data = d;
        s_last = l;
        s_valid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            hs = s_rdy[0];
            tick();
            if (hs) break;
        end
        if (!hs) check("send_timeout", 0, 1);
    endtask

    task automatic stream(input logic [31:0] d, input int n);
        for (int k = 0; k < n; k++) send(d, 1'b0);
        s_valid = 1'b0;
        repeat (8) tick();
    endtask

    function automatic logic [15:0] model(input logic signed [15:0] s, input int g);
        longint p;
        p = longint'(s) * longint'(g) + 64'sd2048;
        p = p >>> 12;
        if (p > 64'sd32767) return 16'h7FFF;
        else if (p < -64'sd32768) return 16'h8000;
        else return p[15:0];
    endfunction

    function automatic logic [31:0] ramp_word(input int k);
        logic [15:0] iv;
        logic [15:0] qv;
        iv = 16'(k * 13 - 32500);
        qv = 16'(30000 - k * 11);
        return {iv, qv};
    endfunction

    initial begin
        vecs[0] = '{32'h03E8FC18, 1'b0, 32'h03E8FC18, 32'h07D0F830};
        vecs[1] = '{32'h7FFF8000, 1'b0, 32'h7FFF8000, 32'h7FFF8000};
        vecs[2] = '{32'h4E20B1E0, 1'b1, 32'h4E20B1E0, 32'h7FFF8000};
        vecs[3] = '{32'h0001FFFF, 1'b0, 32'h0001FFFF, 32'h0002FFFE};
        vecs[4] = '{32'h40002000, 1'b1, 32'h40002000, 32'h7FFF4000};
        vecs[5] = '{32'h80007FFF, 1'b1, 32'h80007FFF, 32'h80007FFF};

        // Reset state
        do_reset(3);
        check("rst_valid", m_valid[0], 0);
        check("rst_data", m_data[0], 0);
        check("rst_last", m_last[0], 0);
        check("rst_gain_a", gain[0], 16'h1000);
        check("rst_gain_b", gain[1], 16'h2000);
        check("rst_gain_c", gain[2], 16'h0080);
        check("rst_mean", mean[0], 0);
        check("rst_stb", stb[0], 0);
        check("rst_ready", s_rdy[0], 1);

        // Single samples: latency, pass-through at 1.0, rounding and saturation at 2.0
        for (int v = 0; v < 6; v++) begin
            do_reset(2);
            send(vecs[v].din, vecs[v].last);
            s_valid = 1'b0;
            tick();
            check("lat_early", m_valid[0], 0);
            tick();
            check("lat_valid", m_valid[0], 1);
            check("vec_data_a", m_data[0], vecs[v].exp_a);
            check("vec_last_a", m_last[0], vecs[v].last);
            check("vec_data_b", m_data[1], vecs[v].exp_b);
        end

        // Loop step: one full window at I = Q = 2048
        do_reset(2);
        for (int k = 0; k < 1024; k++) send(32'h08000800, k == 1023);
        s_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (stb[0]) break;
        end
        check("step_stb", stb[0], 1);
        check("step_mean", mean[0], 17'd4096);
        check("step_gain_before", gain[0], 16'h1000);
        tick();
        check("step_stb_pulse", stb[0], 0);
        check("step_gain", gain[0], 16'h1100);
        send(32'h08000800, 1'b1);
        s_valid = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (m_valid[0]) break;
            tick();
        end
        check("step_scaled", m_data[0], 32'h08800880);

        // Reset mid-packet drops in-flight samples and restores the loop
        send(32'h01000100, 1'b0);
        send(32'h01000100, 1'b0);
        send(32'h01000100, 1'b0);
        check("midrst_inflight", m_valid[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_valid = 1'b0;
        check("midrst_valid", m_valid[0], 0);
        check("midrst_gain", gain[0], 16'h1000);
        check("midrst_mean", mean[0], 0);
        begin
            int seen;
            seen = 0;
            for (int t = 0; t < 6; t++) begin
                tick();
                if (m_valid[0]) seen++;
            end
            check("midrst_no_output", seen, 0);
        end

        // Clamp: zeros drive B up by 512 per window to GAIN_MAX; C stays put
        do_reset(2);
        stream(32'd0, 4);
        check("clamp_b_first", gain[1], 16'h2200);
        check("clamp_c_zero_err", gain[2], 16'h0080);
        stream(32'd0, 440);
        check("clamp_b_below_max", gain[1], 16'hFE00);
        stream(32'd0, 4);
        check("clamp_b_max", gain[1], 16'hFFFF);
        stream(32'd0, 8);
        check("clamp_b_hold_max", gain[1], 16'hFFFF);
        // Full-scale input: B steps down, C clamps at GAIN_MIN
        stream(32'h7FFF7FFF, 4);
        check("clamp_b_mean_fs", mean[1], 17'd65534);
        check("clamp_b_down", gain[1], 16'hF1FF);
        check("clamp_c_mean", mean[2], 17'd2048);
        check("clamp_c_min", gain[2], 16'h0040);
        stream(32'h7FFF7FFF, 4);
        check("clamp_c_mean2", mean[2], 17'd1024);
        check("clamp_c_hold_min", gain[2], 16'h0040);
        check("clamp_b_down2", gain[1], 16'hE3FF);

        // Backpressure with freeze: order, tlast, stall rule, frozen gain
        freeze = 1'b1;
        do_reset(2);
        qa.delete();
        qb.delete();
        stb_cnt = 0;
        stall_err = 0;
        mon_on = 1'b1;
        bp_on = 1'b1;
        for (int k = 0; k < 5000; k++) send(ramp_word(k), (k % 7) == 6);
        s_valid = 1'b0;
        for (int t = 0; t < 40000; t++) begin
            if (qa.size() >= 5000 && qb.size() >= 5000) break;
            tick();
        end
        bp_on = 1'b0;
        repeat (4) tick();
        mon_on = 1'b0;
        check("bp_count_a", qa.size(), 5000);
        check("bp_count_b", qb.size(), 5000);
        begin
            int bad_a;
            int bad_b;
            logic [31:0] w;
            logic [32:0] ea;
            logic [32:0] eb;
            bad_a = 0;
            bad_b = 0;
            for (int k = 0; k < 5000; k++) begin
                w = ramp_word(k);
                ea = {(k % 7) == 6, model(w[31:16], 4096), model(w[15:0], 4096)};
                eb = {(k % 7) == 6, model(w[31:16], 8192), model(w[15:0], 8192)};
                if (k < qa.size() && qa[k] !== ea) bad_a++;
                if (k < qb.size() && qb[k] !== eb) bad_b++;
            end
            check("bp_order_a", bad_a, 0);
            check("bp_order_b", bad_b, 0);
        end
        check("bp_stall_ready", stall_err, 0);
        check("freeze_stb_count", stb_cnt, 4);
        check("freeze_gain_a", gain[0], 16'h1000);
        check("freeze_gain_b", gain[1], 16'h2000);
        freeze = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
